// File: rtl/sd_blk_arbiter_if.sv
// Purpose : bundles the four-drive request side and the shared host side of the block arbiter.
// Latency : n/a (wires only).
// Backpress: level request/ack handshake; drives hold requests until acked, host holds ack for the block.
// Ports   : drv_* per-drive request/data/ack, host_* shared host request/data/ack, grant/busy/timeout_err status.
//           modport master = arbiter view, modport slave = drives/host environment view.
interface sd_blk_arbiter_if;
    logic [3:0]       drv_rd;
    logic [3:0]       drv_wr;
    logic [3:0][31:0] drv_lba;
    logic [3:0][7:0]  drv_buff_din;
    logic [3:0]       drv_ack;
    logic [3:0]       drv_buff_wr;
    logic [31:0]      host_lba;
    logic             host_rd;
    logic             host_wr;
    logic             host_ack;
    logic             host_buff_wr;
    logic [7:0]       host_buff_din;
    logic [1:0]       grant;
    logic             busy;
    logic             timeout_err;

    modport master (
        input  drv_rd, drv_wr, drv_lba, drv_buff_din, host_ack, host_buff_wr,
        output drv_ack, drv_buff_wr, host_lba, host_rd, host_wr, host_buff_din,
               grant, busy, timeout_err
    );

    modport slave (
        output drv_rd, drv_wr, drv_lba, drv_buff_din, host_ack, host_buff_wr,
        input  drv_ack, drv_buff_wr, host_lba, host_rd, host_wr, host_buff_din,
               grant, busy, timeout_err
    );
endinterface

// File: rtl/sd_blk_arbiter.sv
// Purpose : round-robin arbiter sharing one host block port among four drive controllers.
// Latency : host_rd/host_wr rise one edge after a request is seen in IDLE; acks/strobes routed combinationally.
// Backpress: host request held until host_ack, a watchdog abort, or withdrawal by the granted drive.
// Ports   : CLK, RESET_N (synchronous, active low); bus = sd_blk_arbiter_if.master carrying the
//           drive-side requests/LBAs/data/acks, the shared host request/ack/data and grant/busy/timeout_err.
module sd_blk_arbiter #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
    input  logic               CLK,
    input  logic               RESET_N,
    sd_blk_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t      state_q, state_nxt;
    logic [1:0]  grant_q, grant_nxt;
    logic [1:0]  last_q, last_nxt;
    logic        op_wr_q, op_wr_nxt;
    logic [31:0] lba_q, lba_nxt;
    logic        host_rd_q, host_rd_nxt;
    logic        host_wr_q, host_wr_nxt;
    logic [23:0] wd_q, wd_nxt;
    logic        terr_q, terr_nxt;

    logic [1:0]  rr_idx;
    logic        rr_found;
    logic        req_live;
    logic        busy;

    // Round-robin pick: first requester after the last owner, wrapping mod 4.
    always_comb begin
        logic [1:0] cand;
        rr_idx   = last_q + 2'd1;
        rr_found = 1'b0;
        cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!rr_found && (bus.drv_rd[cand] || bus.drv_wr[cand])) begin
                rr_idx   = cand;
                rr_found = 1'b1;
            end
        end
    end

    // The owner still wants the operation it was granted for.
    assign req_live = op_wr_q ? bus.drv_wr[grant_q] : bus.drv_rd[grant_q];

    always_comb begin
        state_nxt   = state_q;
        grant_nxt   = grant_q;
        last_nxt    = last_q;
        op_wr_nxt   = op_wr_q;
        lba_nxt     = lba_q;
        host_rd_nxt = host_rd_q;
        host_wr_nxt = host_wr_q;
        wd_nxt      = wd_q;
        terr_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt   = rr_idx;
                    lba_nxt     = bus.drv_lba[rr_idx];
                    // Read wins a simultaneous read+write; the write is served later.
                    op_wr_nxt   = !bus.drv_rd[rr_idx];
                    host_rd_nxt = bus.drv_rd[rr_idx];
                    host_wr_nxt = !bus.drv_rd[rr_idx];
                    wd_nxt      = 24'd0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (bus.host_ack) begin
                    host_rd_nxt = 1'b0;
                    host_wr_nxt = 1'b0;
                    state_nxt   = XFER;
                end else if (!req_live) begin
                    host_rd_nxt = 1'b0;
                    host_wr_nxt = 1'b0;
                    last_nxt    = grant_q;
                    state_nxt   = IDLE;
                end else if (wd_q == TIMEOUT_CYC - 24'd1) begin
                    host_rd_nxt = 1'b0;
                    host_wr_nxt = 1'b0;
                    terr_nxt    = 1'b1;
                    last_nxt    = grant_q;
                    state_nxt   = IDLE;
                end else begin
                    wd_nxt = wd_q + 24'd1;
                end
            end
            XFER: begin
                // Drive withdrawal is ignored here; only the host ends a transfer.
                if (!bus.host_ack) begin
                    last_nxt  = grant_q;
                    state_nxt = IDLE;
                end
            end
            default: begin
                host_rd_nxt = 1'b0;
                host_wr_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            grant_q   <= 2'd0;
            last_q    <= 2'd3;
            op_wr_q   <= 1'b0;
            lba_q     <= 32'd0;
            host_rd_q <= 1'b0;
            host_wr_q <= 1'b0;
            wd_q      <= 24'd0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            grant_q   <= grant_nxt;
            last_q    <= last_nxt;
            op_wr_q   <= op_wr_nxt;
            lba_q     <= lba_nxt;
            host_rd_q <= host_rd_nxt;
            host_wr_q <= host_wr_nxt;
            wd_q      <= wd_nxt;
            terr_q    <= terr_nxt;
        end
    end

    assign busy = (state_q != IDLE);

    always_comb begin
        bus.drv_ack     = 4'd0;
        bus.drv_buff_wr = 4'd0;
        for (int i = 0; i < 4; i++) begin
            bus.drv_ack[i]     = bus.host_ack && busy && (grant_q == 2'(i));
            // Host strobes outside the data phase are dropped.
            bus.drv_buff_wr[i] = bus.host_buff_wr && (state_q == XFER) && (grant_q == 2'(i));
        end
    end

    assign bus.host_buff_din = busy ? bus.drv_buff_din[grant_q] : 8'h00;
    assign bus.host_lba      = lba_q;
    assign bus.host_rd       = host_rd_q;
    assign bus.host_wr       = host_wr_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy;
    assign bus.timeout_err   = terr_q;

endmodule

// File: tb/tb_sd_blk_arbiter.sv
module tb_sd_blk_arbiter;
    localparam logic [23:0] TMO = 24'd16;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    sd_blk_arbiter_if bus();

    sd_blk_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int pulse_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Behavioural model: who owns the host port, for which op, and how long it has waited.
    bit          m_busy = 1'b0, m_xfer = 1'b0, m_wr = 1'b0, m_terr = 1'b0;
    int          m_own = 0, m_last = 3, m_wait = 0;
    logic [31:0] m_lba = 32'd0;

    always @(posedge CLK) begin : model
        bit nb, nx, nw, nt, found;
        int no, nl, nwt, c;
        logic [31:0] nlba;
        nb = m_busy; nx = m_xfer; nw = m_wr; nt = 1'b0;
        no = m_own; nl = m_last; nwt = m_wait; nlba = m_lba;
        found = 1'b0; c = 0;
        if (!RESET_N) begin
            nb = 0; nx = 0; nw = 0; no = 0; nl = 3; nwt = 0; nlba = 32'd0;
        end else if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (!found && (bus.drv_rd[c] || bus.drv_wr[c])) begin
                    found = 1'b1;
                    no    = c;
                    nw    = !bus.drv_rd[c];
                    nlba  = bus.drv_lba[c];
                end
            end
            if (found) begin nb = 1; nx = 0; nwt = 0; end
        end else if (!m_xfer) begin
            if (bus.host_ack) nx = 1;
            else if (!(m_wr ? bus.drv_wr[m_own] : bus.drv_rd[m_own])) begin nb = 0; nl = m_own; end
            else if (m_wait + 1 == int'(TMO)) begin nb = 0; nt = 1; nl = m_own; end
            else nwt = m_wait + 1;
        end else if (!bus.host_ack) begin
            nb = 0; nx = 0; nl = m_own;
        end
        m_busy <= nb; m_xfer <= nx; m_wr <= nw; m_terr <= nt;
        m_own <= no; m_last <= nl; m_wait <= nwt; m_lba <= nlba;
    end

    always @(negedge CLK) begin : compare
        logic [3:0] e_ack, e_bw;
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                e_ack[i] = bus.host_ack && m_busy && (m_own == i);
                e_bw[i]  = bus.host_buff_wr && m_xfer && (m_own == i);
            end
            chk("m_busy", bus.busy, m_busy);
            chk("m_host_rd", bus.host_rd, m_busy && !m_xfer && !m_wr);
            chk("m_host_wr", bus.host_wr, m_busy && !m_xfer && m_wr);
            chk("m_timeout_err", bus.timeout_err, m_terr);
            chk("m_drv_ack", bus.drv_ack, e_ack);
            chk("m_drv_buff_wr", bus.drv_buff_wr, e_bw);
            chk("m_host_buff_din", bus.host_buff_din, m_busy ? bus.drv_buff_din[m_own] : 8'h00);
            if (m_busy) begin
                chk("m_grant", bus.grant, m_own);
                chk("m_host_lba", bus.host_lba, m_lba);
            end
        end
    end

    always @(negedge CLK) if (bus.drv_buff_wr[0]) pulse_cnt <= pulse_cnt + 1;

    task automatic do_reset();
        bus.drv_rd = 4'd0; bus.drv_wr = 4'd0;
        bus.host_ack = 1'b0; bus.host_buff_wr = 1'b0;
        RESET_N = 1'b0;
        step(); step();
        RESET_N = 1'b1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!(bus.host_rd || bus.host_wr) && n < 50) begin step(); n++; end
        chk("req_seen", bus.host_rd || bus.host_wr, 1);
    endtask

    task automatic host_xfer(input int dly, input int len, input logic [3:0] clr_rd,
                             input logic [3:0] clr_wr, output int n, output int g,
                             output bit wr, output logic [31:0] lba, output logic [7:0] din);
        wait_req(n);
        g = bus.grant; wr = bus.host_wr; lba = bus.host_lba; din = bus.host_buff_din;
        repeat (dly) step();
        bus.host_ack = 1'b1;
        bus.drv_rd = bus.drv_rd & ~clr_rd;
        bus.drv_wr = bus.drv_wr & ~clr_wr;
        step();
        bus.host_buff_wr = 1'b1;
        repeat (len) step();
        bus.host_ack = 1'b0;
        bus.host_buff_wr = 1'b0;
        step();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n, g, p0, cnt;
        bit w;
        logic [31:0] lba;
        logic [7:0] din;
        int exp_g[5];
        exp_g = '{0, 1, 2, 3, 0};

        bus.drv_rd = 4'd0; bus.drv_wr = 4'd0;
        bus.host_ack = 1'b0; bus.host_buff_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.drv_lba[i]      = 32'h1000 + 32'(i);
            bus.drv_buff_din[i] = 8'h10 + 8'(i);
        end
        step();
        chk_en = 1'b1;
        step();
        RESET_N = 1'b1;

        // Reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_host_rd", bus.host_rd, 0);
        chk("rst_host_wr", bus.host_wr, 0);
        chk("rst_host_lba", bus.host_lba, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);

        // Single read of 512 bytes from drive 0
        bus.drv_lba[0] = 32'h0000_0123;
        bus.drv_rd = 4'b0001;
        p0 = pulse_cnt;
        host_xfer(3, 512, 4'b0001, 4'b0000, n, g, w, lba, din);
        chk("t1_req_latency", n, 1);
        chk("t1_grant", g, 0);
        chk("t1_is_read", w, 0);
        chk("t1_lba", lba, 32'h123);
        chk("t1_pulses", pulse_cnt - p0, 512);
        chk("t1_idle", bus.busy, 0);

        // Round robin with all drives requesting
        do_reset();
        bus.drv_rd = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            host_xfer(1, 8, 4'b0000, 4'b0000, n, g, w, lba, din);
            chk("t2_grant", g, exp_g[i]);
            chk("t2_latency", n, 1);
        end
        bus.drv_rd = 4'b0000;

        // Read and write together on drive 2: read first, then write
        do_reset();
        bus.drv_buff_din[2] = 8'hA5;
        bus.drv_rd = 4'b0100;
        bus.drv_wr = 4'b0100;
        host_xfer(1, 4, 4'b0100, 4'b0000, n, g, w, lba, din);
        chk("t3a_grant", g, 2);
        chk("t3a_is_read", w, 0);
        chk("t3a_din", din, 8'hA5);
        bus.drv_buff_din[2] = 8'h5A;
        host_xfer(1, 4, 4'b0000, 4'b0100, n, g, w, lba, din);
        chk("t3b_grant", g, 2);
        chk("t3b_is_write", w, 1);
        chk("t3b_din", din, 8'h5A);

        // Watchdog abort on drive 2 write, then search resumes at drive 3
        do_reset();
        bus.drv_wr = 4'b0100;
        wait_req(n);
        chk("t4_host_wr", bus.host_wr, 1);
        cnt = 0;
        while (!bus.timeout_err && cnt < 40) begin step(); cnt++; end
        chk("t4_timeout_cycles", cnt, 16);
        chk("t4_host_wr_low", bus.host_wr, 0);
        bus.drv_wr = 4'b0000;
        bus.drv_rd = 4'b1011;
        step();
        chk("t4_terr_pulse", bus.timeout_err, 0);
        chk("t4_next_grant", bus.grant, 3);
        host_xfer(1, 3, 4'b1011, 4'b0000, n, g, w, lba, din);
        chk("t4_xfer_grant", g, 3);

        // Reset in the middle of a drive 1 transfer
        do_reset();
        bus.drv_rd = 4'b0010;
        wait_req(n);
        bus.host_ack = 1'b1;
        bus.drv_rd = 4'b0000;
        step(); step();
        chk("t5_in_xfer", bus.drv_ack, 4'b0010);
        RESET_N = 1'b0;
        step();
        chk("t5_busy", bus.busy, 0);
        chk("t5_host_rd", bus.host_rd, 0);
        chk("t5_host_wr", bus.host_wr, 0);
        chk("t5_drv_ack", bus.drv_ack, 0);
        RESET_N = 1'b1;
        bus.host_ack = 1'b0;
        bus.drv_rd = 4'b0011;
        host_xfer(1, 3, 4'b0011, 4'b0000, n, g, w, lba, din);
        chk("t5_first_grant", g, 0);

        // Drive 3 withdraws before the host acks; LBA stays latched meanwhile
        do_reset();
        bus.drv_lba[3] = 32'hCAFE_0003;
        bus.drv_rd = 4'b1000;
        wait_req(n);
        chk("t6_grant", bus.grant, 3);
        bus.drv_lba[3] = 32'h0;
        step();
        chk("t6_lba_held", bus.host_lba, 32'hCAFE_0003);
        chk("t6_still_req", bus.host_rd, 1);
        bus.drv_rd = 4'b0000;
        step();
        chk("t6_host_rd", bus.host_rd, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_terr", bus.timeout_err, 0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sd_blk_arbiter.md
SD_BLK_ARBITER -- requirements
Module: sd_blk_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 24'd5000000: cycles allowed from host request assertion to host_ack rise before abort.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET_N  input  1  synchronous, active-low reset.
REQ-004 drv_rd  input  4  per-drive block read request from the four wd1793 instances; level, held until acknowledged.
REQ-005 drv_wr  input  4  per-drive block write request; level, held until acknowledged.
REQ-006 drv_lba  input  4x32  per-drive LBA; sampled at grant.
REQ-007 drv_buff_din  input  4x8  per-drive write data toward host.
REQ-008 drv_ack  output  4  per-drive ack, routed from host_ack.
REQ-009 drv_buff_wr  output  4  per-drive buffer write strobe.
REQ-010 host_lba  output  32  LBA of granted transfer.
REQ-011 host_rd  output  1  single shared host read request.
REQ-012 host_wr  output  1  single shared host write request.
REQ-013 host_ack  input  1  host acknowledge; high for the whole block transfer.
REQ-014 host_buff_wr  input  1  host buffer write strobe (read data valid).
REQ-015 host_buff_din  output  8  write data muxed from granted drive.
REQ-016 grant  output  2  index of owning drive; valid while busy=1.
REQ-017 busy  output  1  high in REQ or XFER.
REQ-018 timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-019 States IDLE, REQ, XFER; exactly one active.
REQ-020 IDLE: if (drv_rd|drv_wr)!=0, select requester by round-robin, search order last_grant+1, +2, +3, +4 (mod 4); latch grant, host_lba<=drv_lba[grant], op; next state REQ.
REQ-021 Op latch: drv_rd[i] and drv_wr[i] both high -> read wins; write stays pending for a later grant.
REQ-022 REQ: host_rd or host_wr (per latched op) registered high starting the cycle after grant; exactly one of them high.
REQ-023 REQ: host_ack rising (sampled high) -> deassert host_rd/host_wr same edge, enter XFER.
REQ-024 XFER: host_ack sampled low -> IDLE, last_grant<=grant; earliest new grant on the following cycle (one IDLE cycle minimum between transfers).
REQ-025 drv_ack[i] = host_ack & busy & (grant==i), combinational; all other bits 0.
REQ-026 drv_buff_wr[i] = host_buff_wr & (state==XFER) & (grant==i), combinational; strobes outside XFER dropped.
REQ-027 host_buff_din = drv_buff_din[grant] when busy, else 8'h00.
REQ-028 Watchdog: 24-bit counter cleared on entry to REQ, increments each REQ cycle; reaching TIMEOUT_CYC-1 without host_ack -> host_rd/host_wr 0, timeout_err pulse 1 cycle, last_grant<=grant, IDLE.
REQ-029 Requester withdrawal: granted drive's request bit for latched op low while in REQ -> drop host request next edge, IDLE, last_grant<=grant, no timeout_err.
REQ-030 Withdrawal in XFER ignored; transfer completes on host_ack fall.
REQ-031 host_lba, grant, op stable from grant until return to IDLE; drv_lba changes during busy ignored.
REQ-032 Fairness: a continuously requesting drive is granted within 4 transfers.

Reset
REQ-033 RESET_N low at a clock edge: state IDLE, host_rd=0, host_wr=0, host_lba=0, grant=0, last_grant=3, watchdog=0, timeout_err=0; effective mid-transfer, takes priority over all transitions.
REQ-034 After reset release, first grant goes to lowest-indexed requester (drive 0 if requesting).

Verification
REQ-035 drv_rd=4'b0001, drv_lba[0]=32'h0000_0123; host raises ack 3 cycles after host_rd, holds 512 cycles with host_buff_wr -> host_rd high 1 cycle after grant, host_lba=32'h123, drv_ack=4'b0001, drv_buff_wr[0] pulses 512 times, return to IDLE.
REQ-036 drv_rd=4'b1111 held continuously, each host transfer 10 cycles -> grant sequence 0,1,2,3,0.
REQ-037 drv_rd[2]=1, drv_wr[2]=1 together -> first transfer read (host_rd), second write (host_wr); host_buff_din follows drv_buff_din[2].
REQ-038 TIMEOUT_CYC=24'd16, drv_wr=4'b0100, host_ack never rises -> host_wr low and timeout_err=1 for one cycle 16 cycles after host_wr rise; next grant starts search at drive 3.
REQ-039 RESET_N low for one cycle during XFER of drive 1 -> next cycle busy=0, host_rd=host_wr=0, drv_ack=0; with drv_rd=4'b0011 afterward, drive 0 granted first.
REQ-040 Drive 3 drops drv_rd in REQ before host_ack -> host_rd low next cycle, no timeout_err, IDLE.
